// File: rtl/alu32_nibble_seq.sv
// Multi-cycle 32-bit ALU: single-cycle logic ops and a slice-serial adder/subtractor
// behind a start/ready handshake. Define ALU32_SAT_EN to saturate ADD/SUB results on signed overflow.
module alu32_nibble_seq #(
  parameter int ADD_STEP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v
);

  localparam int N  = 32 / ADD_STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_INV  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_XNOR = 3'b100,
    OP_NOR  = 3'b101,
    OP_ADD  = 3'b110,
    OP_SUB  = 3'b111
  } op_e;

  state_e              state, state_next;
  op_e                 op_q;
  logic [31:0]         a_q, b_q;
  logic [31:0]         acc_q, acc_next;
  logic                carry_q;
  logic [CW-1:0]       slice_q;

  logic                accept, finish, is_arith, last_slice;
  logic [ADD_STEP-1:0] slice_a, slice_b, slice_sum;
  logic                slice_cout;
  logic [31:0]         logic_res, fin_result;
  logic                fin_c, fin_v;
  int                  slice_lo;

  assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last_slice = (slice_q == CW'(N - 1));

  // Gate-cell network; b_q already holds ~b for SUB, raw b otherwise.
  always_comb begin
    logic_res = '0;
    case (op_q)
      OP_INV:  logic_res = ~a_q;
      OP_AND:  logic_res = a_q & b_q;
      OP_OR:   logic_res = a_q | b_q;
      OP_XOR:  logic_res = a_q ^ b_q;
      OP_XNOR: logic_res = ~(a_q ^ b_q);
      OP_NOR:  logic_res = ~(a_q | b_q);
      default: logic_res = '0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    slice_lo  = int'(slice_q) * ADD_STEP;
    slice_a   = a_q[slice_lo +: ADD_STEP];
    slice_b   = b_q[slice_lo +: ADD_STEP];
    {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{ADD_STEP{1'b0}}, carry_q};
    acc_next  = acc_q;
    acc_next[slice_lo +: ADD_STEP] = slice_sum;
  end

  // On the last slice acc_next already holds the complete sum.
  always_comb begin
    fin_result = logic_res;
    fin_c      = 1'b0;
    fin_v      = 1'b0;
    if (is_arith) begin
      fin_c      = slice_cout;
      fin_v      = (a_q[31] == b_q[31]) && (acc_next[31] != a_q[31]);
      fin_result = acc_next;
`ifdef ALU32_SAT_EN
      if (fin_v) fin_result = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!is_arith || last_slice) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_INV;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      slice_q <= '0;
    end else if (accept) begin
      op_q    <= op_e'(op);
      a_q     <= a;
      b_q     <= (op_e'(op) == OP_SUB) ? ~b : b;
      carry_q <= (op_e'(op) == OP_SUB);
      acc_q   <= '0;
      slice_q <= '0;
    end else if (state == ST_EXEC && is_arith) begin
      acc_q   <= acc_next;
      carry_q <= slice_cout;
      if (!last_slice) slice_q <= slice_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (finish) begin
      result <= fin_result;
      flag_n <= fin_result[31];
      flag_z <= (fin_result == 32'h0);
      flag_c <= fin_c;
      flag_v <= fin_v;
    end
  end

endmodule

// File: tb/tb_alu32_nibble_seq.sv
// Self-checking bench for alu32_nibble_seq: ADD_STEP=4 and ADD_STEP=32 instances,
// directed cases plus random ops against an arithmetic reference model.
module tb_alu32_nibble_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, start32 = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;

  logic        ready, done, flag_n, flag_z, flag_c, flag_v;
  logic [31:0] result;
  logic        ready32, done32, flag_n32, flag_z32, flag_c32, flag_v32;
  logic [31:0] result32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu32_nibble_seq #(.ADD_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  alu32_nibble_seq #(.ADD_STEP(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .op(op), .a(a), .b(b),
    .ready(ready32), .done(done32), .result(result32),
    .flag_n(flag_n32), .flag_z(flag_z32), .flag_c(flag_c32), .flag_v(flag_v32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit arithmetic, sign rules from operand/result signs.
  task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] res, output logic [3:0] nzcv);
    logic [32:0] wide;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (mop)
      3'd0: res = ~ma;
      3'd1: res = ma & mb;
      3'd2: res = ma | mb;
      3'd3: res = ma ^ mb;
      3'd4: res = ~(ma ^ mb);
      3'd5: res = ~(ma | mb);
      3'd6: begin
        wide = {1'b0, ma} + {1'b0, mb};
        res  = wide[31:0];
        c    = wide[32];
        v    = (ma[31] == mb[31]) && (res[31] != ma[31]);
      end
      default: begin
        wide = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
        res  = wide[31:0];
        c    = wide[32];
        v    = (ma[31] != mb[31]) && (res[31] != ma[31]);
      end
    endcase
`ifdef ALU32_SAT_EN
    if (v) res = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    nzcv = {res[31], res == 32'h0, c, v};
  endtask

  // Issue one op, verify latency, result, flags, single-cycle done, ready return.
  task automatic run_op(input bit wide, input logic [2:0] top, input logic [31:0] ta,
                        input logic [31:0] tb, input string tag);
    logic [31:0] exp_res, obs_res;
    logic [3:0]  exp_nzcv, obs_nzcv;
    int          cycles, exp_lat;
    logic        d;
    model(top, ta, tb, exp_res, exp_nzcv);
    exp_lat = (top >= 3'd6) ? (wide ? 2 : 9) : 2;
    @(negedge clk);
    op = top; a = ta; b = tb;
    if (wide) start32 = 1'b1; else start = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        start = 1'b0; start32 = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
      end
      d = wide ? done32 : done;
    end while (!d && cycles < 40);
    check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
    obs_res  = wide ? result32 : result;
    obs_nzcv = wide ? {flag_n32, flag_z32, flag_c32, flag_v32} : {flag_n, flag_z, flag_c, flag_v};
    check({tag, " result"}, obs_res, exp_res);
    check({tag, " nzcv"}, 32'(obs_nzcv), 32'(exp_nzcv));
    @(negedge clk);
    check({tag, " done width/ready"}, wide ? {done32, ready32} : {done, ready}, 32'b01);
    check({tag, " result hold"}, wide ? result32 : result, exp_res);
  endtask

  initial begin
    logic [2:0]  rop;
    int          pulses;
    logic [31:0] r_exp;
    logic [3:0]  f_exp;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset ready/done", {ready, done}, 32'b10);
    check("reset result", result, 32'h0);
    check("reset nzcv", {flag_n, flag_z, flag_c, flag_v}, 32'h0);
    check("reset32 ready/done", {ready32, done32}, 32'b10);
    check("reset32 result", result32, 32'h0);

    run_op(1'b0, 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, "xor");
    run_op(1'b0, 3'b101, 32'h0, 32'h0, "nor zero");
    run_op(1'b0, 3'b110, 32'hFFFF_FFFF, 32'h1, "add wrap");
    run_op(1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1, "add wrap step32");
    run_op(1'b0, 3'b110, 32'h7FFF_FFFF, 32'h1, "add overflow");
    run_op(1'b1, 3'b110, 32'h7FFF_FFFF, 32'h1, "add overflow step32");
    run_op(1'b0, 3'b110, 32'h8000_0000, 32'h8000_0000, "add neg overflow");
    run_op(1'b0, 3'b111, 32'd5, 32'd7, "sub borrow");
    run_op(1'b0, 3'b111, 32'd7, 32'd5, "sub no borrow");
    run_op(1'b0, 3'b000, 32'h1234_5678, 32'h0, "inv");

    // Start pulsed again during EXEC must not be queued: exactly one done.
    model(3'b110, 32'h0000_1111, 32'h0000_2222, r_exp, f_exp);
    @(negedge clk);
    op = 3'b110; a = 32'h0000_1111; b = 32'h0000_2222; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("restart ignored done count", 32'(pulses), 32'd1);
    check("restart ignored result", result, r_exp);

    // Abort an ADD in EXEC cycle 4.
    @(negedge clk);
    op = 3'b110; a = 32'h0F0F_0F0F; b = 32'h0101_0101; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort done", {31'b0, done}, 32'h0);
    check("abort result", result, 32'h0);
    check("abort ready", {31'b0, ready}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    run_op(1'b0, 3'b110, 32'h0F0F_0F0F, 32'h0101_0101, "after abort");

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom);
      run_op(1'b0, rop, $urandom, $urandom, "random");
    end
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom);
      run_op(1'b1, rop, $urandom, $urandom, "random32");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
